// File: rtl/alu_pkg.sv
// Shared types and constants for the pipelined multi-cycle ALU: opcodes,
// control states, flag bit positions and the multi-cycle opcode classifier.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB,
    OP_INC,
    OP_DEC,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_NOT,
    OP_SHL,
    OP_SHR,
    OP_ROL,
    OP_ROR,
    OP_MUL,
    OP_DIV,
    OP_MOD
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } alu_state_t;

  // Positions inside flags = {DZ, V, N, C, Z}
  localparam int FLAG_Z  = 0;
  localparam int FLAG_C  = 1;
  localparam int FLAG_N  = 2;
  localparam int FLAG_V  = 3;
  localparam int FLAG_DZ = 4;
  localparam int FLAGS_W = 5;

  function automatic logic is_multicycle(input alu_op_t op);
    return op inside {OP_MUL, OP_DIV, OP_MOD};
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative datapath: one shift-add (MUL) or restoring shift-subtract
// (DIV/MOD) step per cycle, WORD_SIZE steps, then done is raised.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = 19
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  alu_op_t              op,
  input  logic [WORD_SIZE-1:0] operand_a,
  input  logic [WORD_SIZE-1:0] operand_b,
  output logic                 done,
  output logic [WORD_SIZE-1:0] result,
  output logic                 carry
);

  localparam int CNT_W = $clog2(WORD_SIZE + 1);

  logic                 busy;
  logic [CNT_W-1:0]     cnt;
  logic [WORD_SIZE-1:0] hi;    // MUL: product upper half; DIV/MOD: partial remainder
  logic [WORD_SIZE-1:0] lo;    // MUL: multiplier / product low half; DIV/MOD: quotient
  logic [WORD_SIZE-1:0] m;     // multiplicand or divisor
  alu_op_t              mode;

  logic [WORD_SIZE:0] mul_sum;
  logic [WORD_SIZE:0] div_shift;
  logic               div_ge;

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    div_shift = {hi, lo[WORD_SIZE-1]};
    div_ge    = (div_shift >= {1'b0, m});
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too; they are few and it keeps
    // result deterministic straight out of reset.
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
      m    <= '0;
      mode <= OP_MUL;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CNT_W'(WORD_SIZE);
      hi   <= '0;
      mode <= op;
      if (op == OP_MUL) begin
        lo <= operand_b;
        m  <= operand_a;
      end else begin
        lo <= operand_a;
        m  <= operand_b;
      end
    end else if (busy) begin
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
        if (mode == OP_MUL) begin
          hi <= mul_sum[WORD_SIZE:1];
          lo <= {mul_sum[0], lo[WORD_SIZE-1:1]};
        end else begin
          // Remainder is always below the divisor, so it fits WORD_SIZE bits
          hi <= div_ge ? WORD_SIZE'(div_shift - {1'b0, m}) : WORD_SIZE'(div_shift);
          lo <= {lo[WORD_SIZE-2:0], div_ge};
        end
      end
    end
  end

  assign done   = busy && (cnt == '0);
  assign result = (mode == OP_MOD) ? hi : lo;
  assign carry  = (mode == OP_MUL) && (|hi);

endmodule

// File: rtl/pipelined_alu_mc.sv
// Registered ALU with flags: single-cycle ops complete in one cycle,
// MUL/DIV/MOD run on the iterative datapath behind a valid/ready handshake.
module pipelined_alu_mc
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = 19,
  parameter int OPCODE_W  = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPCODE_W-1:0]  alu_op,
  input  logic [WORD_SIZE-1:0] operand_1,
  input  logic [WORD_SIZE-1:0] operand_2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] result,
  output logic [FLAGS_W-1:0]   flags
);

  localparam int CNT_W = $clog2(WORD_SIZE + 1);
  localparam int MSB   = WORD_SIZE - 1;

  alu_op_t    op;
  alu_state_t state;
  logic       ready_en;   // holds in_ready low until the first edge after reset

  logic [WORD_SIZE-1:0] addend;
  logic [WORD_SIZE:0]   sum, diff, shl_ext, shr_ext;
  logic [CNT_W-1:0]     amt;
  logic [WORD_SIZE-1:0] sc_res;
  logic                 sc_c, sc_v, sc_dz;
  logic [FLAGS_W-1:0]   sc_flags, iter_flags;
  logic                 div_by_zero, accept, start;
  logic                 iter_done, iter_carry;
  logic [WORD_SIZE-1:0] iter_result;

  assign op = alu_op_t'(alu_op);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    addend  = (op == OP_INC || op == OP_DEC) ? WORD_SIZE'(1) : operand_2;
    sum     = {1'b0, operand_1} + {1'b0, addend};
    diff    = {1'b0, operand_1} - {1'b0, addend};
    amt     = CNT_W'(operand_2 % WORD_SIZE);
    shl_ext = {1'b0, operand_1} << amt;
    shr_ext = {operand_1, 1'b0} >> amt;
    sc_res  = '0;
    sc_c    = 1'b0;
    sc_v    = 1'b0;
    sc_dz   = 1'b0;
    case (op)
      OP_ADD, OP_INC: begin
        sc_res = sum[MSB:0];
        sc_c   = sum[WORD_SIZE];
        sc_v   = (operand_1[MSB] == addend[MSB]) && (sum[MSB] != operand_1[MSB]);
      end
      OP_SUB, OP_DEC: begin
        sc_res = diff[MSB:0];
        sc_c   = diff[WORD_SIZE];
        sc_v   = (operand_1[MSB] != addend[MSB]) && (diff[MSB] != operand_1[MSB]);
      end
      OP_AND: sc_res = operand_1 & operand_2;
      OP_OR:  sc_res = operand_1 | operand_2;
      OP_XOR: sc_res = operand_1 ^ operand_2;
      OP_NOT: sc_res = ~operand_1;
      OP_SHL: begin
        sc_res = shl_ext[MSB:0];
        sc_c   = shl_ext[WORD_SIZE];
      end
      OP_SHR: begin
        sc_res = shr_ext[WORD_SIZE:1];
        sc_c   = shr_ext[0];
      end
      OP_ROL: sc_res = (operand_1 << amt) | (operand_1 >> (WORD_SIZE - int'(amt)));
      OP_ROR: sc_res = (operand_1 >> amt) | (operand_1 << (WORD_SIZE - int'(amt)));
      // Only reached on this path when the divisor is zero
      OP_DIV: begin
        sc_res = '1;
        sc_dz  = 1'b1;
      end
      OP_MOD: begin
        sc_res = operand_1;
        sc_dz  = 1'b1;
      end
      default: ;
    endcase
    sc_flags          = '0;
    sc_flags[FLAG_Z]  = (sc_res == '0);
    sc_flags[FLAG_N]  = sc_res[MSB];
    sc_flags[FLAG_C]  = sc_c;
    sc_flags[FLAG_V]  = sc_v;
    sc_flags[FLAG_DZ] = sc_dz;

    iter_flags         = '0;
    iter_flags[FLAG_Z] = (iter_result == '0);
    iter_flags[FLAG_N] = iter_result[MSB];
    iter_flags[FLAG_C] = iter_carry;
  end

  assign in_ready    = ready_en && (state == IDLE) && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign div_by_zero = (op == OP_DIV || op == OP_MOD) && (operand_2 == '0);
  assign start       = accept && is_multicycle(op) && !div_by_zero;

  alu_iter_muldiv #(.WORD_SIZE(WORD_SIZE)) u_iter (
    .clk       (CLK),
    .rst_n     (RESET),
    .start     (start),
    .op        (op),
    .operand_a (operand_1),
    .operand_b (operand_2),
    .done      (iter_done),
    .result    (iter_result),
    .carry     (iter_carry)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      ready_en  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else begin
      ready_en <= 1'b1;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (start) begin
            state <= BUSY;
          end else begin
            out_valid <= 1'b1;
            result    <= sc_res;
            flags     <= sc_flags;
          end
        end
        BUSY: if (iter_done) begin
          state     <= DONE;
          out_valid <= 1'b1;
          result    <= iter_result;
          flags     <= iter_flags;
        end
        DONE: if (out_valid && out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
